imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Sequencer that owns the 256-word instruction memory. After reset it boot-loads the memory from a byte stream supplied by the serial receiver. It then runs the fetch loop: it generates the PC, reads the memory, and presents registered PC/instruction pairs to decode. It honours stall and branch/jump redirect from the core.

Parameters:
DEPTH, 256, number of 32-bit words in instruction memory
ADDR_W, 8, word-index width (log2 DEPTH)
RESET_PC, 32'h0000_0000, first fetch byte address after load

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-low reset
rx_data  in  8  boot byte from serial receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
imem_we  out  1  memory write enable
imem_waddr  out  ADDR_W  memory write word index
imem_wdata  out  32  memory write word
imem_raddr  out  ADDR_W  memory read word index (combinational read)
imem_rdata  in  32  memory read data, same cycle as imem_raddr
stall  in  1  hold fetch outputs
redirect  in  1  take new PC (branch/jump)
redirect_pc  in  32  target byte address
pc  out  32  byte address of inst
inst  out  32  fetched instruction
inst_valid  out  1  pc/inst valid for decode
loading  out  1  high while boot-load is in progress
misalign_err  out  1  sticky: redirect_pc[1:0] was non-zero

Behaviour:
- Reset (RST=0 at a clock edge) puts the FSM in S_COUNT.
  - Reset values: pc=0, inst=0, inst_valid=0, imem_we=0, imem_waddr=0, imem_wdata=0, misalign_err=0, loading=1.
  - Internal counters are cleared; fetch_pc=RESET_PC.
- FSM states: S_COUNT, S_LOAD, S_RUN.
- S_COUNT: waits for the first rx_valid. That byte is N, the word count.
  - N=0: go to S_RUN; memory is untouched.
  - N>0: store N, clear word and byte counters, go to S_LOAD.
- S_LOAD: on each rx_valid, shift the byte into the word assembler, little-endian (the first byte of a word lands in [7:0]).
  - On the 4th byte: imem_we=1 for exactly one cycle, imem_waddr=word counter, imem_wdata=assembled word.
  - The write strobe occurs the cycle after the 4th rx_valid, then the word counter increments.
  - After word N-1 is written, go to S_RUN the following cycle.
  - Cycles without rx_valid hold all state.
- loading=1 in S_COUNT and S_LOAD; 0 in S_RUN.
- inst_valid=0 throughout loading.
- rx_valid in S_RUN is ignored.
- S_RUN, every cycle:
  - imem_raddr = fetch_pc[ADDR_W+1:2]. PCs beyond DEPTH*4 wrap modulo DEPTH.
- S_RUN, priority redirect > stall > advance:
  - redirect=1: fetch_pc <= {redirect_pc[31:2],2'b00}, inst_valid <= 0 (one bubble), pc/inst hold. If redirect_pc[1:0]!=0, misalign_err <= 1 (sticky until reset).
  - stall=1 (no redirect): pc, inst, inst_valid, fetch_pc all hold.
  - Otherwise: pc <= fetch_pc, inst <= imem_rdata, inst_valid <= 1, fetch_pc <= fetch_pc+4 (32-bit wrap).
- Latency: an instruction appears on pc/inst one cycle after its address is on imem_raddr. The first inst_valid=1 comes 1 cycle after S_RUN is entered.
- A redirect arriving while stall is high is still taken immediately.
- Reset mid-load aborts the load and returns to S_COUNT. Words already written stay in memory; a partially assembled word is discarded.
- Reset mid-run re-enters S_COUNT; a new boot stream is then required.

Decomposition:
- Shared package/header: the FSM state encodings (S_COUNT=2'd0, S_LOAD=2'd1, S_RUN=2'd2), the instruction width of 32, and RESET_PC.
- Natural sub-module: boot_word_assembler (byte shift register, byte counter, word-ready strobe).
- The PC/fetch register logic stays in the top level.

Test Plan:
- Boot with N=2 and bytes 13,05,00,00,93,05,10,00 -> imem_we pulses twice: addr0=32'h00000513, addr1=32'h00100593. loading falls after the second write.
- N=0 -> S_RUN the next cycle, no imem_we. The first inst_valid comes one cycle later with pc=0.
- Run 3 cycles with mem[0..2]=A,B,C and no stall -> pc 0,4,8 with inst A,B,C on consecutive cycles, inst_valid=1.
- stall=1 for 2 cycles while pc=4 -> pc=4 and inst=B hold. The next cycle gives pc=8, inst=C.
- redirect=1 with redirect_pc=32'h20 together with stall=1 -> the next cycle has inst_valid=0. The following cycle gives pc=32'h20, inst=mem[8].
- redirect_pc=32'h22 -> misalign_err=1 and it stays set; fetch resumes at 32'h20.
- Reset after 2 of 4 bytes of word 0 -> loading=1, S_COUNT. A new stream N=1 writes addr0 correctly.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot loader and fetch sequencer.
package imem_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        S_COUNT = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam int unsigned INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/imem_fetch_ctrl_assembler.sv
// Boot word assembler: packs four received bytes little-endian into one 32-bit word.
module imem_fetch_ctrl_assembler
    import imem_fetch_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              word_done_o,
    output logic [INST_W-1:0] word_o
);

    logic [1:0]  cnt_q;
    logic [23:0] shift_q;

    // The 4th byte completes the word directly, so only three bytes are stored.
    assign word_done_o = byte_valid_i && (cnt_q == 2'd3);
    assign word_o      = {byte_i, shift_q};

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (byte_valid_i) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {byte_i, shift_q[23:8]};
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Boot-loads instruction memory from a byte stream, then runs the PC/fetch loop with stall and redirect.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W-1:0] imem_raddr,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       pc,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic              loading,
    output logic              misalign_err
);

    state_t              state_q, state_d;
    logic [7:0]          n_q;
    logic [ADDR_W-1:0]   wcnt_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [31:0]         wdata_q;
    logic                we_q, last_q;
    logic [31:0]         fetch_pc_q, pc_q, inst_q;
    logic                valid_q, misalign_q;
    logic                asm_en, asm_clr, word_done;
    logic [INST_W-1:0]   word;

    imem_fetch_ctrl_assembler u_asm (
        .clk_i        (CLK),
        .rst_ni       (RST),
        .clr_i        (asm_clr),
        .byte_valid_i (asm_en),
        .byte_i       (rx_data),
        .word_done_o  (word_done),
        .word_o       (word)
    );

    always_comb begin
        state_d = state_q;
        asm_en  = 1'b0;
        asm_clr = (state_q != S_LOAD);
        unique case (state_q)
            S_COUNT: if (rx_valid) state_d = (rx_data == 8'd0) ? S_RUN : S_LOAD;
            // Leave one cycle after the final write strobe; bytes in that cycle are dropped.
            S_LOAD:  if (we_q && last_q) state_d = S_RUN;
                     else asm_en = rx_valid;
            S_RUN:   ;
            default: state_d = S_COUNT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= S_COUNT;
            n_q        <= '0;
            wcnt_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            last_q     <= 1'b0;
            fetch_pc_q <= RESET_PC;
            pc_q       <= '0;
            inst_q     <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= word_done;
            if (state_q == S_COUNT && rx_valid) begin
                n_q    <= rx_data;
                wcnt_q <= '0;
            end
            if (word_done) begin
                waddr_q <= wcnt_q;
                wdata_q <= word;
                last_q  <= (wcnt_q == ADDR_W'(n_q - 8'd1));
                wcnt_q  <= wcnt_q + 1'b1;
            end
            if (state_q == S_RUN) begin
                if (redirect) begin
                    fetch_pc_q <= {redirect_pc[31:2], 2'b00};
                    valid_q    <= 1'b0;
                    if (redirect_pc[1:0] != 2'b00) misalign_q <= 1'b1;
                end else if (!stall) begin
                    pc_q       <= fetch_pc_q;
                    inst_q     <= imem_rdata;
                    valid_q    <= 1'b1;
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
            end
        end
    end

    assign imem_raddr   = fetch_pc_q[ADDR_W+1:2];
    assign imem_we      = we_q;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign pc           = pc_q;
    assign inst         = inst_q;
    assign inst_valid   = valid_q;
    assign loading      = (state_q != S_RUN);
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl with a behavioural 256-word memory.
module tb_imem_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [7:0]  imem_raddr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        loading;
    logic        misalign_err;

    logic [31:0] mem [0:255];
    int          wr_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    imem_fetch_ctrl #(.DEPTH(256), .ADDR_W(8), .RESET_PC(32'h0)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .imem_raddr   (imem_raddr),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .pc           (pc),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .loading      (loading),
        .misalign_err (misalign_err)
    );

    always #5 CLK = ~CLK;

    assign imem_rdata = mem[imem_raddr];

    always @(posedge CLK) begin
        if (imem_we === 1'b1) begin
            mem[imem_waddr] <= imem_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        tick();
        tick();
        RST = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0; rx_valid = 1'b0; rx_data = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick(); tick();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=%h", inst, 32'h0); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
        checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", imem_we); end
        checks++; if (imem_waddr !== 8'h0 || imem_wdata !== 32'h0) begin failures++;
            $display("FAIL reset_wport got=%h/%h exp=00/00000000", imem_waddr, imem_wdata); end
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
        checks++; if (loading !== 1'b1) begin failures++; $display("FAIL reset_loading got=%b exp=1", loading); end
        RST = 1'b1;
    endtask

    task automatic test_boot();
        logic [7:0]  bs [8];
        logic [31:0] exp_w [2];
        int          w0;
        bs = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        exp_w = '{32'h0000_0513, 32'h0010_0593};
        do_reset();
        w0 = wr_cnt;
        send_byte(8'd2);
        tick();
        for (int i = 0; i < 8; i++) begin
            send_byte(bs[i]);
            if (i % 4 == 3) begin
                checks++; if (imem_we !== 1'b1 || imem_waddr !== 8'(i / 4) || imem_wdata !== exp_w[i / 4]) begin
                    failures++;
                    $display("FAIL boot_write%0d got=we%b a%h d%h exp=we1 a%h d%h", i / 4, imem_we, imem_waddr,
                             imem_wdata, 8'(i / 4), exp_w[i / 4]);
                end
                checks++; if (loading !== 1'b1) begin failures++; $display("FAIL boot_loading_w%0d got=%b exp=1", i / 4, loading); end
            end
            tick();
            checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL boot_we_pulse%0d got=%b exp=0", i, imem_we); end
        end
        checks++; if (loading !== 1'b0) begin failures++; $display("FAIL boot_loading_fall got=%b exp=0", loading); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL boot_first_valid got=%b exp=0", inst_valid); end
        checks++; if (wr_cnt - w0 !== 2) begin failures++; $display("FAIL boot_write_count got=%0d exp=2", wr_cnt - w0); end
        tick();
        checks++; if (inst_valid !== 1'b1 || pc !== 32'h0 || inst !== 32'h0000_0513) begin failures++;
            $display("FAIL boot_first_fetch got=v%b pc%h i%h exp=v1 pc00000000 i00000513", inst_valid, pc, inst); end
    endtask

    task automatic test_zero_and_run();
        int w0;
        do_reset();
        mem[0] = 32'hAAAA_0001; mem[1] = 32'hBBBB_0002; mem[2] = 32'hCCCC_0003;
        w0 = wr_cnt;
        send_byte(8'd0);
        checks++; if (loading !== 1'b0 || inst_valid !== 1'b0) begin failures++;
            $display("FAIL zero_enter_run got=l%b v%b exp=l0 v0", loading, inst_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (inst_valid !== 1'b1 || pc !== 32'(4 * i) || inst !== mem[i]) begin failures++;
                $display("FAIL run_seq%0d got=v%b pc%h i%h exp=v1 pc%h i%h", i, inst_valid, pc, inst, 32'(4 * i), mem[i]); end
        end
        checks++; if (wr_cnt !== w0) begin failures++; $display("FAIL zero_no_write got=%0d exp=%0d", wr_cnt, w0); end
    endtask

    task automatic test_stall_redirect();
        do_reset();
        mem[0] = 32'hA0; mem[1] = 32'hB1; mem[2] = 32'hC2;
        mem[8] = 32'hD8; mem[9] = 32'hE9; mem[255] = 32'hFF00_00FF;
        send_byte(8'd0);
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc !== 32'h4 || inst !== 32'hB1 || inst_valid !== 1'b1) begin failures++;
                $display("FAIL stall_hold%0d got=v%b pc%h i%h exp=v1 pc00000004 i000000b1", i, inst_valid, pc, inst); end
        end
        stall = 1'b0;
        tick();
        checks++; if (pc !== 32'h8 || inst !== 32'hC2) begin failures++;
            $display("FAIL stall_release got=pc%h i%h exp=pc00000008 i000000c2", pc, inst); end
        redirect = 1'b1; redirect_pc = 32'h20; stall = 1'b1;
        tick();
        redirect = 1'b0; stall = 1'b0;
        checks++; if (inst_valid !== 1'b0 || pc !== 32'h8) begin failures++;
            $display("FAIL redirect_bubble got=v%b pc%h exp=v0 pc00000008", inst_valid, pc); end
        tick();
        checks++; if (inst_valid !== 1'b1 || pc !== 32'h20 || inst !== 32'hD8 || misalign_err !== 1'b0) begin failures++;
            $display("FAIL redirect_target got=v%b pc%h i%h m%b exp=v1 pc00000020 i000000d8 m0", inst_valid, pc, inst, misalign_err); end
        redirect = 1'b1; redirect_pc = 32'h22;
        tick();
        redirect = 1'b0;
        checks++; if (misalign_err !== 1'b1 || inst_valid !== 1'b0) begin failures++;
            $display("FAIL misalign_set got=m%b v%b exp=m1 v0", misalign_err, inst_valid); end
        tick();
        checks++; if (pc !== 32'h20 || inst !== 32'hD8 || misalign_err !== 1'b1) begin failures++;
            $display("FAIL misalign_resume got=pc%h i%h m%b exp=pc00000020 i000000d8 m1", pc, inst, misalign_err); end
        tick();
        checks++; if (pc !== 32'h24 || inst !== 32'hE9 || misalign_err !== 1'b1) begin failures++;
            $display("FAIL misalign_sticky got=pc%h i%h m%b exp=pc00000024 i000000e9 m1", pc, inst, misalign_err); end
        redirect = 1'b1; redirect_pc = 32'h3FC;
        tick();
        redirect = 1'b0;
        tick();
        checks++; if (pc !== 32'h3FC || inst !== 32'hFF00_00FF) begin failures++;
            $display("FAIL wrap_last got=pc%h i%h exp=pc000003fc iff0000ff", pc, inst); end
        tick();
        checks++; if (pc !== 32'h400 || inst !== 32'hA0) begin failures++;
            $display("FAIL wrap_mod got=pc%h i%h exp=pc00000400 i000000a0", pc, inst); end
    endtask

    task automatic test_reset_midload();
        do_reset();
        mem[0] = 32'h0;
        send_byte(8'd4);
        send_byte(8'hAA);
        send_byte(8'hBB);
        RST = 1'b0;
        tick();
        checks++; if (loading !== 1'b1 || imem_we !== 1'b0) begin failures++;
            $display("FAIL midload_reset got=l%b we%b exp=l1 we0", loading, imem_we); end
        RST = 1'b1;
        send_byte(8'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        checks++; if (imem_we !== 1'b1 || imem_waddr !== 8'h0 || imem_wdata !== 32'h4433_2211) begin failures++;
            $display("FAIL reload_write got=we%b a%h d%h exp=we1 a00 d44332211", imem_we, imem_waddr, imem_wdata); end
        tick();
        checks++; if (loading !== 1'b0 || mem[0] !== 32'h4433_2211) begin failures++;
            $display("FAIL reload_done got=l%b mem0=%h exp=l0 mem0=44332211", loading, mem[0]); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_boot();
        test_zero_and_run();
        test_stall_redirect();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
